// File: rtl/cmul_result_buffer_if.sv
// Handshake and status bundle between the complex-multiplier result buffer and its environment.
// The buffer connects through the slave modport; the driving environment uses master.
interface cmul_result_buffer_if #(
   parameter int unsigned pDATA_WIDTH = 128,
   parameter int unsigned pDEPTH      = 32
);
   localparam int unsigned CntW = $clog2(pDEPTH) + 1;

   logic                   issue;
   logic                   issue_ok;
   logic [pDATA_WIDTH-1:0] mul_result;
   logic                   mul_ready;
   logic [pDATA_WIDTH-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [CntW-1:0]        count;
   logic [CntW-1:0]        inflight;
   logic                   overflow;
   logic                   proto_err;

   modport slave (
      input  issue,
      input  mul_result,
      input  mul_ready,
      input  out_ready,
      output issue_ok,
      output out_data,
      output out_valid,
      output count,
      output inflight,
      output overflow,
      output proto_err
   );

   modport master (
      output issue,
      output mul_result,
      output mul_ready,
      output out_ready,
      input  issue_ok,
      input  out_data,
      input  out_valid,
      input  count,
      input  inflight,
      input  overflow,
      input  proto_err
   );
endinterface

// File: rtl/cmul_result_buffer.sv
// Credit-managed first-word-fall-through FIFO that absorbs the complex multiplier's fixed-latency
// results. Upstream issue is gated so every in-flight operation already owns a free slot.
module cmul_result_buffer #(
   parameter int unsigned pDATA_WIDTH = 128,
   parameter int unsigned pDEPTH      = 32
) (
   input logic                 clk,
   input logic                 rstn,
   cmul_result_buffer_if.slave bus
);
   localparam int unsigned PtrW = $clog2(pDEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full        = CntW'(pDEPTH);
   localparam logic [CntW-1:0] InflightMax = CntW'(2 * pDEPTH - 1);
   localparam logic [CntW:0]   DepthWide   = (CntW + 1)'(pDEPTH);

   logic [pDATA_WIDTH-1:0] mem_q [pDEPTH];

   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q;
   logic [PtrW-1:0] rd_ptr_d;
   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_d;
   logic [CntW-1:0] inflight_q;
   logic [CntW-1:0] inflight_d;
   logic            overflow_q;
   logic            overflow_d;
   logic            proto_err_q;
   logic            proto_err_d;

   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            credit_ok;
   logic [CntW:0]   committed;

   always_comb begin
      full      = (count_q == Full);
      empty     = (count_q == '0);
      // One extra bit: inflight can legally exceed pDEPTH after protocol violations.
      committed = {1'b0, inflight_q} + {1'b0, count_q};
      credit_ok = (committed < DepthWide);
      pop       = !empty && bus.out_ready;
      push      = bus.mul_ready && (!full || pop);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      inflight_d = inflight_q;
      if (bus.issue && !bus.mul_ready) begin
         if (inflight_q != InflightMax) begin
            inflight_d = inflight_q + 1'b1;
         end
      end else if (bus.mul_ready && !bus.issue) begin
         if (inflight_q != '0) begin
            inflight_d = inflight_q - 1'b1;
         end
      end
   end

   always_comb begin
      overflow_d  = overflow_q | (bus.mul_ready & full & !pop);
      proto_err_d = proto_err_q
                    | (bus.issue & !credit_ok)
                    | (bus.mul_ready & (inflight_q == '0));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         inflight_q  <= '0;
         overflow_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         inflight_q  <= inflight_d;
         overflow_q  <= overflow_d;
         proto_err_q <= proto_err_d;
      end
   end

   // Storage is deliberately left out of reset; out_data is only meaningful under out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.mul_result;
      end
   end

   assign bus.issue_ok  = credit_ok;
   assign bus.out_valid = !empty;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign bus.count     = count_q;
   assign bus.inflight  = inflight_q;
   assign bus.overflow  = overflow_q;
   assign bus.proto_err = proto_err_q;

endmodule
